spi_master_cs: RTL and testbench

Parametrised SPI master: successor to the fixed 8-bit, fixed-mode master. Adds configurable word width, runtime-selectable SPI mode and clock divider, and integrated multi-device chip-select with setup, hold and inter-transaction gap timing. Multi-word transactions keep CS asserted between words. Sits between the CPU-side peripheral register block and the board SPI pins (flash, SD, expansion devices).

---
 rtl/spi_master_cs.sv | 218 +++++++++++++++++++++
 tb/tb_spi_master_cs.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cs.sv
// SPI master with configurable word width and runtime mode/divider. Drives multi-device
// chip selects with setup, hold and gap timing. All pin outputs are registered.
module spi_master_cs #(
  parameter int DATA_W   = 8,
  parameter int NUM_CS   = 2,
  parameter int DIV_W    = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4,
  localparam int SEL_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [1:0]        i_Mode,
  input  logic [DIV_W-1:0]  i_Half_Div,
  input  logic [SEL_W-1:0]  i_CS_Sel,
  input  logic [DATA_W-1:0] i_TX_Word,
  input  logic              i_TX_Last,
  input  logic              i_TX_DV,
  output logic              o_TX_Ready,
  output logic              o_RX_DV,
  output logic [DATA_W-1:0] o_RX_Word,
  output logic              o_Busy,
  output logic              o_SPI_Clk,
  output logic              o_SPI_MOSI,
  input  logic              i_SPI_MISO,
  output logic [NUM_CS-1:0] o_SPI_CS_n
);

  localparam int EDGE_W = $clog2(2*DATA_W) + 1;
  localparam int T_MAX  = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                               : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
  localparam int TMR_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    hcnt_q, hcnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                rx_dv_q, rx_dv_d;
  logic [DATA_W-1:0]   rx_word_q, rx_word_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                accept, ld, ld_cpha, leading;

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [SEL_W-1:0] sel);
    cs_decode = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == SEL_W'(i)) cs_decode[i] = 1'b0;
    end
  endfunction

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      mode_q    <= 2'b00;
      div_q     <= DIV_W'(1);
      hcnt_q    <= '0;
      edge_q    <= '0;
      tmr_q     <= '0;
      last_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
      rx_dv_q   <= 1'b0;
      rx_word_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      hcnt_q    <= hcnt_d;
      edge_q    <= edge_d;
      tmr_q     <= tmr_d;
      last_q    <= last_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      rx_dv_q   <= rx_dv_d;
      rx_word_q <= rx_word_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    div_d     = div_q;
    hcnt_d    = hcnt_q;
    edge_d    = edge_q;
    tmr_d     = tmr_q;
    last_d    = last_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    rx_dv_d   = 1'b0;
    rx_word_d = rx_word_q;
    ld        = 1'b0;
    ld_cpha   = mode_q[0];
    leading   = ~edge_q[0];
    accept    = i_TX_DV && ready_q;

    case (state_q)
      IDLE: begin
        sclk_d = i_Mode[1];
        if (accept) begin
          mode_d  = i_Mode;
          div_d   = (i_Half_Div == '0) ? DIV_W'(1) : i_Half_Div;
          cs_n_d  = cs_decode(i_CS_Sel);
          ld      = 1'b1;
          ld_cpha = i_Mode[0];
          tmr_d   = TMR_W'(CS_SETUP - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tmr_q == '0) begin
          hcnt_d  = div_q - DIV_W'(1);
          edge_d  = '0;
          state_d = SHIFT;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      SHIFT: begin
        // One settling cycle after the last edge so the final trailing sample lands in rx_q.
        if (edge_q == EDGE_W'(2*DATA_W)) begin
          rx_word_d = rx_q;
          rx_dv_d   = 1'b1;
          if (last_q) begin
            tmr_d   = TMR_W'(CS_HOLD - 1);
            state_d = HOLD;
          end else begin
            state_d = WAIT;
          end
        end else if (hcnt_q == '0) begin
          hcnt_d = div_q - DIV_W'(1);
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          if (mode_q[0] == leading) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end else if (mode_q[0] == 1'b1 || edge_q == '0 || leading) begin
            rx_d = {rx_q[DATA_W-2:0], i_SPI_MISO};
          end
          // CPHA=0: the final trailing edge carries no new MOSI bit.
          if (!mode_q[0] && !leading && edge_q == EDGE_W'(2*DATA_W-1)) begin
            mosi_d = mosi_q;
            tx_d   = tx_q;
          end
        end else begin
          hcnt_d = hcnt_q - DIV_W'(1);
        end
      end
      WAIT: begin
        if (accept) begin
          ld      = 1'b1;
          hcnt_d  = div_q - DIV_W'(1);
          edge_d  = '0;
          state_d = SHIFT;
        end
      end
      HOLD: begin
        if (tmr_q == '0) begin
          cs_n_d  = '1;
          tmr_d   = TMR_W'(CS_GAP - 1);
          state_d = GAP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      GAP: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      default: state_d = IDLE;
    endcase

    if (ld) begin
      last_d = i_TX_Last;
      if (!ld_cpha) begin
        mosi_d = i_TX_Word[DATA_W-1];
        tx_d   = {i_TX_Word[DATA_W-2:0], 1'b0};
      end else begin
        tx_d = i_TX_Word;
      end
    end

    ready_d = (state_d == IDLE) || (state_d == WAIT);
    busy_d  = (state_d != IDLE);
  end

  assign o_TX_Ready = ready_q;
  assign o_RX_DV    = rx_dv_q;
  assign o_RX_Word  = rx_word_q;
  assign o_Busy     = busy_q;
  assign o_SPI_Clk  = sclk_q;
  assign o_SPI_MOSI = mosi_q;
  assign o_SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_cs.sv
// Directed bench for spi_master_cs: an 8-bit instance with a mode-aware slave model
// and a 16-bit instance for the mid-word reset scenario.
module tb_spi_master_cs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tx_last, tx_dv, ready, rx_dv, busy, sclk, mosi, miso, cs_sel;
  logic [1:0] mode, cs_n;
  logic [7:0] half_div, tx_word, rx_word;

  logic        rst16, tx_last16, tx_dv16, ready16, rx_dv16, busy16, sclk16, mosi16, miso16, cs_sel16;
  logic [1:0]  mode16, cs_n16;
  logic [7:0]  half_div16;
  logic [15:0] tx_word16, rx_word16;

  spi_master_cs dut (
    .i_Clk(clk), .i_Rst(rst), .i_Mode(mode), .i_Half_Div(half_div), .i_CS_Sel(cs_sel),
    .i_TX_Word(tx_word), .i_TX_Last(tx_last), .i_TX_DV(tx_dv), .o_TX_Ready(ready),
    .o_RX_DV(rx_dv), .o_RX_Word(rx_word), .o_Busy(busy), .o_SPI_Clk(sclk),
    .o_SPI_MOSI(mosi), .i_SPI_MISO(miso), .o_SPI_CS_n(cs_n)
  );

  spi_master_cs #(.DATA_W(16)) dut16 (
    .i_Clk(clk), .i_Rst(rst16), .i_Mode(mode16), .i_Half_Div(half_div16), .i_CS_Sel(cs_sel16),
    .i_TX_Word(tx_word16), .i_TX_Last(tx_last16), .i_TX_DV(tx_dv16), .o_TX_Ready(ready16),
    .o_RX_DV(rx_dv16), .o_RX_Word(rx_word16), .o_Busy(busy16), .o_SPI_Clk(sclk16),
    .o_SPI_MOSI(mosi16), .i_SPI_MISO(miso16), .o_SPI_CS_n(cs_n16)
  );

  bit         loopback;
  logic       s_miso;
  logic [7:0] s_tx, s_rx, slave_word;
  assign miso   = loopback ? mosi : s_miso;
  assign miso16 = mosi16;

  int n_err = 0;
  int n_chk = 0;
  int cyc;
  int m_edges, m_first_edge, m_last_edge, m_mark, m_edge_after, m_stall_edges, m_mosi_bad;
  int m_cs_low, m_cs_bad, m_cs_rise, m_first_rise, m_last_fall, m_rxdv, m_rxdv_cyc, m_ready_cyc;
  int rxdv16_cnt;
  bit m_in_stall;
  logic       m_prev_sclk, m_prev_mosi, lead, samp;
  logic [1:0] m_prev_cs, exp_cs;
  logic [7:0] rx_hist [8];

  // Per-cycle observer plus slave model; samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (sclk !== m_prev_sclk) begin
      m_edges++;
      if (m_first_edge < 0) m_first_edge = cyc;
      m_last_edge = cyc;
      if (m_mark >= 0 && cyc > m_mark && m_edge_after < 0) m_edge_after = cyc;
      if (m_in_stall) m_stall_edges++;
      lead = (m_prev_sclk === mode[1]);
      samp = (lead == !mode[0]);
      if (mosi !== m_prev_mosi && samp) m_mosi_bad++;
    end
    if (cs_n[cs_sel] === 1'b1) begin
      s_tx   = slave_word;
      s_miso = slave_word[7];
    end else if (sclk !== m_prev_sclk) begin
      if (samp) s_rx = {s_rx[6:0], mosi};
      else begin
        s_miso = s_tx[7];
        s_tx   = {s_tx[6:0], 1'b0};
      end
      if (!mode[0] && !lead) s_miso = s_tx[7];
    end
    if (cs_n !== 2'b11) begin
      m_cs_low++;
      if (cs_n !== exp_cs) m_cs_bad++;
    end
    if (cs_n === 2'b11 && m_prev_cs !== 2'b11) begin
      if (m_cs_rise == 0) m_first_rise = cyc;
      m_cs_rise++;
    end
    if (cs_n !== 2'b11 && m_prev_cs === 2'b11) m_last_fall = cyc;
    if (rx_dv === 1'b1) begin
      if (m_rxdv < 8) rx_hist[m_rxdv] = rx_word;
      m_rxdv++;
      m_rxdv_cyc = cyc;
    end
    if (ready === 1'b1 && m_cs_rise > 0 && m_ready_cyc < 0) m_ready_cyc = cyc;
    if (rx_dv16 === 1'b1) rxdv16_cnt++;
    m_prev_sclk = sclk;
    m_prev_mosi = mosi;
    m_prev_cs   = cs_n;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    cyc = 0; m_edges = 0; m_first_edge = -1; m_last_edge = -1; m_mark = -1; m_edge_after = -1;
    m_stall_edges = 0; m_mosi_bad = 0; m_cs_low = 0; m_cs_bad = 0; m_cs_rise = 0;
    m_first_rise = -1; m_last_fall = -1; m_rxdv = 0; m_rxdv_cyc = -1; m_ready_cyc = -1;
    m_in_stall = 1'b0;
    m_prev_sclk = sclk; m_prev_mosi = mosi; m_prev_cs = cs_n;
  endtask

  task automatic send(input logic [7:0] w, input logic last);
    tx_word = w; tx_last = last; tx_dv = 1'b1;
    tick();
    tx_dv = 1'b0;
  endtask

  task automatic wait_ready(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (ready === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (ready === 1'b1 && busy === 1'b0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst16 = 1'b1; tx_dv = 1'b1;
    tick(); tick();
    n_chk++; if (cs_n !== 2'b11) begin n_err++; $display("FAIL rst_cs_n: got %b want 11", cs_n); end
    n_chk++; if (sclk !== 1'b0) begin n_err++; $display("FAIL rst_sclk: got %b want 0", sclk); end
    n_chk++; if (mosi !== 1'b0) begin n_err++; $display("FAIL rst_mosi: got %b want 0", mosi); end
    n_chk++; if (rx_dv !== 1'b0) begin n_err++; $display("FAIL rst_rx_dv: got %b want 0", rx_dv); end
    n_chk++; if (rx_word !== 8'h00) begin n_err++; $display("FAIL rst_rx_word: got %h want 00", rx_word); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_chk++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_during: got %b want 0", ready); end
    n_chk++; if (cs_n16 !== 2'b11) begin n_err++; $display("FAIL rst_cs_n16: got %b want 11", cs_n16); end
    tx_dv = 1'b0; rst = 1'b0; rst16 = 1'b0;
    tick();
    n_chk++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b want 1", ready); end
  endtask

  task automatic test_mode0();
    bit ok;
    mode = 2'd0; half_div = 8'd2; cs_sel = 1'b1; exp_cs = 2'b01; loopback = 1'b1;
    tick(); tick();
    clear_stats();
    send(8'hA5, 1'b1);
    wait_idle(200, ok);
    tick();
    n_chk++; if (ok !== 1'b1) begin n_err++; $display("FAIL mode0_timeout: got %b want 1", ok); end
    n_chk++; if (m_cs_low !== 37) begin n_err++; $display("FAIL mode0_cs_low: got %0d want 37", m_cs_low); end
    n_chk++; if (m_cs_bad !== 0) begin n_err++; $display("FAIL mode0_cs_pattern: got %0d bad want 0", m_cs_bad); end
    n_chk++; if (m_edges !== 16) begin n_err++; $display("FAIL mode0_edges: got %0d want 16", m_edges); end
    n_chk++; if (m_first_edge !== 5) begin n_err++; $display("FAIL mode0_first_edge: got %0d want 5", m_first_edge); end
    n_chk++; if (m_last_edge !== 35) begin n_err++; $display("FAIL mode0_last_edge: got %0d want 35", m_last_edge); end
    n_chk++; if (m_rxdv !== 1) begin n_err++; $display("FAIL mode0_rxdv_cnt: got %0d want 1", m_rxdv); end
    n_chk++; if (m_rxdv_cyc !== 36) begin n_err++; $display("FAIL mode0_rxdv_cyc: got %0d want 36", m_rxdv_cyc); end
    n_chk++; if (rx_hist[0] !== 8'hA5) begin n_err++; $display("FAIL mode0_rx_word: got %h want a5", rx_hist[0]); end
    n_chk++; if (m_first_rise !== 38) begin n_err++; $display("FAIL mode0_cs_rise: got %0d want 38", m_first_rise); end
    n_chk++; if (m_ready_cyc !== 42) begin n_err++; $display("FAIL mode0_ready_cyc: got %0d want 42", m_ready_cyc); end
    n_chk++; if (m_mosi_bad !== 0) begin n_err++; $display("FAIL mode0_mosi_edge: got %0d want 0", m_mosi_bad); end
  endtask

  task automatic test_modes();
    bit ok;
    for (int m = 1; m < 4; m++) begin
      mode = m[1:0]; half_div = 8'd2; cs_sel = 1'b0; exp_cs = 2'b10;
      loopback = 1'b0; slave_word = 8'hC3;
      tick(); tick();
      n_chk++; if (sclk !== mode[1]) begin n_err++; $display("FAIL mode%0d_idle_sclk: got %b want %b", m, sclk, mode[1]); end
      clear_stats();
      send(8'h3C, 1'b1);
      wait_idle(200, ok);
      tick();
      n_chk++; if (ok !== 1'b1) begin n_err++; $display("FAIL mode%0d_timeout: got %b want 1", m, ok); end
      n_chk++; if (rx_hist[0] !== 8'hC3) begin n_err++; $display("FAIL mode%0d_rx_word: got %h want c3", m, rx_hist[0]); end
      n_chk++; if (s_rx !== 8'h3C) begin n_err++; $display("FAIL mode%0d_slave_rx: got %h want 3c", m, s_rx); end
      n_chk++; if (m_mosi_bad !== 0) begin n_err++; $display("FAIL mode%0d_mosi_edge: got %0d want 0", m, m_mosi_bad); end
      n_chk++; if (m_edges !== 16) begin n_err++; $display("FAIL mode%0d_edges: got %0d want 16", m, m_edges); end
      n_chk++; if (sclk !== mode[1]) begin n_err++; $display("FAIL mode%0d_end_sclk: got %b want %b", m, sclk, mode[1]); end
    end
  endtask

  task automatic test_multi_word();
    bit ok1, ok2, ok3;
    int k;
    mode = 2'd0; half_div = 8'd2; cs_sel = 1'b1; exp_cs = 2'b01; loopback = 1'b1;
    tick(); tick();
    clear_stats();
    send(8'h01, 1'b0);
    wait_ready(100, ok1);
    m_in_stall = 1'b1;
    repeat (10) tick();
    m_in_stall = 1'b0;
    k = cyc;
    m_mark = k;
    send(8'h02, 1'b0);
    wait_ready(100, ok2);
    send(8'h03, 1'b1);
    wait_idle(200, ok3);
    tick();
    n_chk++; if ({ok1, ok2, ok3} !== 3'b111) begin n_err++; $display("FAIL multi_timeout: got %b want 111", {ok1, ok2, ok3}); end
    n_chk++; if (m_stall_edges !== 0) begin n_err++; $display("FAIL multi_stall_sclk: got %0d edges want 0", m_stall_edges); end
    n_chk++; if (m_rxdv !== 3) begin n_err++; $display("FAIL multi_rxdv_cnt: got %0d want 3", m_rxdv); end
    n_chk++; if (rx_hist[0] !== 8'h01) begin n_err++; $display("FAIL multi_rx0: got %h want 01", rx_hist[0]); end
    n_chk++; if (rx_hist[1] !== 8'h02) begin n_err++; $display("FAIL multi_rx1: got %h want 02", rx_hist[1]); end
    n_chk++; if (rx_hist[2] !== 8'h03) begin n_err++; $display("FAIL multi_rx2: got %h want 03", rx_hist[2]); end
    n_chk++; if (m_cs_rise !== 1) begin n_err++; $display("FAIL multi_cs_rises: got %0d want 1", m_cs_rise); end
    n_chk++; if (m_edges !== 48) begin n_err++; $display("FAIL multi_edges: got %0d want 48", m_edges); end
    n_chk++; if (m_edge_after !== k + 3) begin n_err++; $display("FAIL multi_wait_edge: got %0d want %0d", m_edge_after, k + 3); end
    n_chk++; if (m_cs_bad !== 0) begin n_err++; $display("FAIL multi_cs_pattern: got %0d bad want 0", m_cs_bad); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int gap;
    mode = 2'd0; half_div = 8'd1; cs_sel = 1'b0; exp_cs = 2'b10; loopback = 1'b1;
    tick(); tick();
    clear_stats();
    send(8'h5A, 1'b1);
    ok1 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ready === 1'b1) begin ok1 = 1'b1; tx_dv = 1'b0; break; end
      tx_word = 8'hFF; tx_last = 1'b1; tx_dv = 1'b1;
      tick();
    end
    send(8'h66, 1'b1);
    wait_idle(200, ok2);
    tick();
    gap = m_last_fall - m_first_rise;
    n_chk++; if ({ok1, ok2} !== 2'b11) begin n_err++; $display("FAIL b2b_timeout: got %b want 11", {ok1, ok2}); end
    n_chk++; if (m_rxdv !== 2) begin n_err++; $display("FAIL b2b_rxdv_cnt: got %0d want 2", m_rxdv); end
    n_chk++; if (rx_hist[0] !== 8'h5A) begin n_err++; $display("FAIL b2b_rx0: got %h want 5a", rx_hist[0]); end
    n_chk++; if (rx_hist[1] !== 8'h66) begin n_err++; $display("FAIL b2b_rx1: got %h want 66", rx_hist[1]); end
    n_chk++; if (m_cs_rise !== 2) begin n_err++; $display("FAIL b2b_cs_rises: got %0d want 2", m_cs_rise); end
    n_chk++; if (gap < 4) begin n_err++; $display("FAIL b2b_cs_gap: got %0d cycles want at least 4", gap); end
    n_chk++; if (m_edges !== 32) begin n_err++; $display("FAIL b2b_edges: got %0d want 32", m_edges); end
  endtask

  task automatic test_half_div0();
    bit ok;
    mode = 2'd0; half_div = 8'd0; cs_sel = 1'b1; exp_cs = 2'b01; loopback = 1'b1;
    tick(); tick();
    clear_stats();
    send(8'h96, 1'b1);
    wait_idle(200, ok);
    tick();
    n_chk++; if (ok !== 1'b1) begin n_err++; $display("FAIL div0_timeout: got %b want 1", ok); end
    n_chk++; if (rx_hist[0] !== 8'h96) begin n_err++; $display("FAIL div0_rx_word: got %h want 96", rx_hist[0]); end
    n_chk++; if (m_first_edge !== 4) begin n_err++; $display("FAIL div0_first_edge: got %0d want 4", m_first_edge); end
    n_chk++; if (m_last_edge !== 19) begin n_err++; $display("FAIL div0_last_edge: got %0d want 19", m_last_edge); end
    n_chk++; if (m_edges !== 16) begin n_err++; $display("FAIL div0_edges: got %0d want 16", m_edges); end
    n_chk++; if (m_rxdv_cyc !== 20) begin n_err++; $display("FAIL div0_rxdv_cyc: got %0d want 20", m_rxdv_cyc); end
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    mode16 = 2'd0; half_div16 = 8'd2; cs_sel16 = 1'b0;
    tick();
    rxdv16_cnt = 0;
    tx_word16 = 16'hBEEF; tx_last16 = 1'b1; tx_dv16 = 1'b1;
    tick();
    tx_dv16 = 1'b0;
    repeat (20) tick();
    n_chk++; if (cs_n16 !== 2'b10) begin n_err++; $display("FAIL w16_cs_mid: got %b want 10", cs_n16); end
    rst16 = 1'b1;
    tick();
    n_chk++; if (cs_n16 !== 2'b11) begin n_err++; $display("FAIL w16_cs_after_rst: got %b want 11", cs_n16); end
    n_chk++; if (rx_dv16 !== 1'b0) begin n_err++; $display("FAIL w16_rxdv_rst: got %b want 0", rx_dv16); end
    n_chk++; if (sclk16 !== 1'b0) begin n_err++; $display("FAIL w16_sclk_rst: got %b want 0", sclk16); end
    rst16 = 1'b0;
    tick();
    n_chk++; if (ready16 !== 1'b1) begin n_err++; $display("FAIL w16_ready_after: got %b want 1", ready16); end
    n_chk++; if (busy16 !== 1'b0) begin n_err++; $display("FAIL w16_busy_after: got %b want 0", busy16); end
    repeat (80) tick();
    n_chk++; if (rxdv16_cnt !== 0) begin n_err++; $display("FAIL w16_no_partial_rxdv: got %0d want 0", rxdv16_cnt); end
    tx_dv16 = 1'b1;
    tick();
    tx_dv16 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ready16 === 1'b1 && busy16 === 1'b0) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    n_chk++; if (ok !== 1'b1) begin n_err++; $display("FAIL w16_timeout: got %b want 1", ok); end
    n_chk++; if (rxdv16_cnt !== 1) begin n_err++; $display("FAIL w16_rxdv_cnt: got %0d want 1", rxdv16_cnt); end
    n_chk++; if (rx_word16 !== 16'hBEEF) begin n_err++; $display("FAIL w16_rx_word: got %h want beef", rx_word16); end
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; half_div = 8'd2; cs_sel = 1'b0; tx_word = 8'h00; tx_last = 1'b0; tx_dv = 1'b0;
    rst16 = 1'b1; mode16 = 2'd0; half_div16 = 8'd2; cs_sel16 = 1'b0; tx_word16 = 16'h0; tx_last16 = 1'b0;
    tx_dv16 = 1'b0; loopback = 1'b1; s_miso = 1'b0; s_tx = 8'h00; s_rx = 8'h00; slave_word = 8'h00;
    exp_cs = 2'b11; rxdv16_cnt = 0; lead = 1'b0; samp = 1'b0;
    for (int i = 0; i < 8; i++) rx_hist[i] = 8'h00;
    clear_stats();
    m_prev_sclk = 1'b0; m_prev_mosi = 1'b0; m_prev_cs = 2'b11;
    test_reset();
    test_mode0();
    test_modes();
    test_multi_word();
    test_back_to_back();
    test_half_div0();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within bound");
    $fatal(1);
  end

endmodule
